// File: rtl/cache_line_fill_assembler.sv
// Assembles a cache refill line from critical-word-first memory beats and
// forwards the critical word to the CPU before the line is complete.
module cache_line_fill_assembler #(
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fill_req,
  input  logic [ADDR_WIDTH-1:0]       fill_addr,
  output logic                        fill_busy,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  output logic [DATA_WIDTH-1:0]       crit_data,
  output logic                        crit_valid,
  output logic [CACHE_LINE_WIDTH-1:0] line_data,
  output logic [ADDR_WIDTH-1:0]       line_addr,
  output logic                        line_valid,
  input  logic                        line_ready
);

  localparam int WORDS = CACHE_LINE_WIDTH / DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                state, state_next;
  logic [1:0]            ptr;
  logic [1:0]            cnt;
  logic [DATA_WIDTH-1:0] words [WORDS];
  logic                  accept;
  logic                  beat;

  always_comb begin
    state_next = state;
    mem_ready  = 1'b0;
    fill_busy  = 1'b0;
    line_valid = 1'b0;
    accept     = 1'b0;
    beat       = 1'b0;
    case (state)
      IDLE: begin
        accept = fill_req;
        if (fill_req) state_next = FILL;
      end
      FILL: begin
        mem_ready = 1'b1;
        fill_busy = 1'b1;
        beat      = mem_valid;
        if (mem_valid && cnt == 2'd3) state_next = DONE;
      end
      DONE: begin
        fill_busy  = 1'b1;
        line_valid = 1'b1;
        // A fill_req coinciding with the handshake is dropped on purpose.
        if (line_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      cnt        <= 2'd0;
      line_addr  <= '0;
      crit_data  <= '0;
      crit_valid <= 1'b0;
    end else begin
      state      <= state_next;
      crit_valid <= beat && (cnt == 2'd0);
      if (accept) begin
        ptr       <= fill_addr[1:0];
        cnt       <= 2'd0;
        line_addr <= {fill_addr[ADDR_WIDTH-1:2], 2'b00};
      end else if (beat) begin
        ptr <= ptr + 2'd1;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd0) crit_data <= mem_data;
      end
    end
  end

  // Each word slot is cleared at fill start so a previous line never leaks in.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          words[gi] <= '0;
        end else if (accept) begin
          words[gi] <= '0;
        end else if (beat && ptr == 2'(gi)) begin
          words[gi] <= mem_data;
        end
      end
      assign line_data[gi*DATA_WIDTH +: DATA_WIDTH] = words[gi];
    end
  endgenerate

endmodule

// File: tb/tb_cache_line_fill_assembler.sv
// Directed bench for cache_line_fill_assembler: critical-word-first fills,
// stalls, DONE back-pressure, mid-fill reset and the handshake/request race.
module tb_cache_line_fill_assembler;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fill_req = 1'b0;
  logic [31:0]  fill_addr = '0;
  logic         fill_busy;
  logic [31:0]  mem_data = '0;
  logic         mem_valid = 1'b0;
  logic         mem_ready;
  logic [31:0]  crit_data;
  logic         crit_valid;
  logic [127:0] line_data;
  logic [31:0]  line_addr;
  logic         line_valid;
  logic         line_ready = 1'b0;

  int total = 0;
  int bad = 0;

  cache_line_fill_assembler #(.CACHE_LINE_WIDTH(128), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_busy(fill_busy), .mem_data(mem_data), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .crit_data(crit_data), .crit_valid(crit_valid),
    .line_data(line_data), .line_addr(line_addr), .line_valid(line_valid),
    .line_ready(line_ready)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge; inputs set afterwards apply to that cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({fill_busy, mem_ready, crit_valid, line_valid} !== 4'b0) begin bad++;
      $display("FAIL reset_flags got=%b want=0000", {fill_busy, mem_ready, crit_valid, line_valid}); end
    total++; if ({line_data, line_addr, crit_data} !== '0) begin bad++;
      $display("FAIL reset_data line=%h addr=%h crit=%h want=0", line_data, line_addr, crit_data); end
    tick(); rst_n = 1'b1; tick();
    $display("reset: flags=%b", {fill_busy, mem_ready, line_valid});
  endtask

  task automatic test_aligned();
    fill_req = 1'b1; fill_addr = 32'h40; tick();                     // cycle 1
    fill_req = 1'b0;
    total++; if (mem_ready !== 1'b1 || fill_busy !== 1'b1) begin bad++;
      $display("FAIL t1_fill_state ready=%b busy=%b want=1,1", mem_ready, fill_busy); end
    mem_valid = 1'b1; mem_data = 32'hA0; tick();                     // cycle 2
    total++; if (crit_valid !== 1'b1 || crit_data !== 32'hA0) begin bad++;
      $display("FAIL t1_crit valid=%b data=%h want=1,a0", crit_valid, crit_data); end
    mem_data = 32'hA1; tick();                                       // cycle 3
    total++; if (crit_valid !== 1'b0) begin bad++;
      $display("FAIL t1_crit_pulse got=%b want=0", crit_valid); end
    mem_data = 32'hA2; tick();                                       // cycle 4
    total++; if (line_valid !== 1'b0) begin bad++;
      $display("FAIL t1_early_line got=%b want=0", line_valid); end
    mem_data = 32'hA3; tick();                                       // cycle 5
    mem_valid = 1'b0;
    total++; if (line_valid !== 1'b1 || mem_ready !== 1'b0 || fill_busy !== 1'b1) begin bad++;
      $display("FAIL t1_done valid=%b ready=%b busy=%b want=1,0,1", line_valid, mem_ready, fill_busy); end
    total++; if (line_data !== 128'h000000A3_000000A2_000000A1_000000A0 || line_addr !== 32'h40) begin bad++;
      $display("FAIL t1_line data=%h addr=%h", line_data, line_addr); end
    line_ready = 1'b1; tick(); line_ready = 1'b0;
    total++; if (line_valid !== 1'b0 || fill_busy !== 1'b0) begin bad++;
      $display("FAIL t1_idle valid=%b busy=%b want=0,0", line_valid, fill_busy); end
    $display("aligned fill: line=%h addr=%h", 128'h000000A3_000000A2_000000A1_000000A0, 32'h40);
  endtask

  task automatic test_wrap();
    int pulses = 0;
    logic [31:0] beats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    fill_req = 1'b1; fill_addr = 32'h42; tick(); fill_req = 1'b0;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_data = beats[i]; tick();
      if (crit_valid) pulses++;
    end
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (crit_valid) pulses++;
      tick();
    end
    // line still held in DONE: line_ready not yet given
    total++; if (pulses !== 1 || crit_data !== 32'h11) begin bad++;
      $display("FAIL t2_crit pulses=%0d data=%h want=1,11", pulses, crit_data); end
    total++; if (line_valid !== 1'b1 || line_data !== 128'h00000022_00000011_00000044_00000033 || line_addr !== 32'h40) begin bad++;
      $display("FAIL t2_line valid=%b data=%h addr=%h", line_valid, line_data, line_addr); end
    line_ready = 1'b1; tick(); line_ready = 1'b0;
    $display("wrapped fill: line=%h", 128'h00000022_00000011_00000044_00000033);
  endtask

  task automatic test_stall();
    logic [31:0] beats [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    int early = 0;
    fill_req = 1'b1; fill_addr = 32'h40; tick(); fill_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_data = beats[i]; tick();
      if (i < 3) begin
        mem_valid = 1'b0; mem_data = 32'hDEAD0000 + i;
        for (int g = 0; g < 3; g++) begin
          if (line_valid || !mem_ready) early++;
          tick();
        end
      end
    end
    mem_valid = 1'b0;
    total++; if (early !== 0) begin bad++;
      $display("FAIL t3_gap_state bad_cycles=%0d want=0", early); end
    total++; if (line_valid !== 1'b1 || line_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin bad++;
      $display("FAIL t3_line valid=%b data=%h", line_valid, line_data); end
    line_ready = 1'b1; tick(); line_ready = 1'b0;
    $display("stalled fill: line=%h", 128'h000000A3_000000A2_000000A1_000000A0);
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    fill_req = 1'b1; fill_addr = 32'h42; tick(); fill_req = 1'b0;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin mem_data = 32'h11 * (i + 1); tick(); end
    mem_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      fill_req = (c == 2); fill_addr = 32'h100; mem_valid = 1'b1; mem_data = 32'hBAD;
      if (line_valid !== 1'b1 || mem_ready !== 1'b0 || fill_busy !== 1'b1 || line_addr !== 32'h40 ||
          line_data !== 128'h00000022_00000011_00000044_00000033) unstable++;
      tick();
    end
    fill_req = 1'b0; mem_valid = 1'b0;
    total++; if (unstable !== 0) begin bad++;
      $display("FAIL t4_hold unstable_cycles=%0d want=0", unstable); end
    line_ready = 1'b1; tick(); line_ready = 1'b0;
    total++; if (line_valid !== 1'b0 || fill_busy !== 1'b0 || mem_ready !== 1'b0) begin bad++;
      $display("FAIL t4_release valid=%b busy=%b ready=%b want=0,0,0", line_valid, fill_busy, mem_ready); end
    $display("backpressure: held 5 cycles, released");
  endtask

  task automatic test_mid_reset();
    fill_req = 1'b1; fill_addr = 32'h43; tick(); fill_req = 1'b0;
    mem_valid = 1'b1; mem_data = 32'h77; tick(); mem_data = 32'h88; tick();
    mem_valid = 1'b0;
    rst_n = 1'b0; #1;
    total++; if ({fill_busy, mem_ready, crit_valid, line_valid} !== 4'b0 || {line_data, line_addr, crit_data} !== '0) begin bad++;
      $display("FAIL t5_async_reset flags=%b line=%h addr=%h crit=%h want=0", {fill_busy, mem_ready, crit_valid, line_valid}, line_data, line_addr, crit_data); end
    tick(); rst_n = 1'b1; tick();
    fill_req = 1'b1; fill_addr = 32'h80; tick(); fill_req = 1'b0;
    mem_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin mem_data = i; tick(); end
    mem_valid = 1'b0;
    total++; if (line_valid !== 1'b1 || line_data !== 128'h00000004_00000003_00000002_00000001 || line_addr !== 32'h80) begin bad++;
      $display("FAIL t5_clean_fill valid=%b data=%h addr=%h", line_valid, line_data, line_addr); end
    line_ready = 1'b1; tick(); line_ready = 1'b0;
    $display("mid-fill reset: next line=%h", 128'h00000004_00000003_00000002_00000001);
  endtask

  task automatic test_back_to_back();
    fill_req = 1'b1; fill_addr = 32'h40; tick(); fill_req = 1'b0;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin mem_data = 32'hC0 + i; tick(); end
    mem_valid = 1'b0;
    line_ready = 1'b1; fill_req = 1'b1; fill_addr = 32'h200; tick();
    line_ready = 1'b0;
    total++; if (fill_busy !== 1'b0 || mem_ready !== 1'b0) begin bad++;
      $display("FAIL t6_race_ignored busy=%b ready=%b want=0,0", fill_busy, mem_ready); end
    tick(); fill_req = 1'b0;
    total++; if (mem_ready !== 1'b1 || fill_busy !== 1'b1) begin bad++;
      $display("FAIL t6_reissue ready=%b busy=%b want=1,1", mem_ready, fill_busy); end
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin mem_data = 32'hD0 + i; tick(); end
    mem_valid = 1'b0;
    total++; if (line_valid !== 1'b1 || line_addr !== 32'h200 || line_data !== 128'h000000D3_000000D2_000000D1_000000D0) begin bad++;
      $display("FAIL t6_line valid=%b addr=%h data=%h", line_valid, line_addr, line_data); end
    line_ready = 1'b1; tick(); line_ready = 1'b0;
    $display("back-to-back: reissued fill addr=%h", 32'h200);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_wrap();
    test_stall();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
